mul4_fitness_scorer: RTL and testbench

Sequential fitness evaluator for evolved 2-bit × 2-bit bit-sliced multiplier individuals (16 independent lanes per vector: lane operand a = {a1,a0}, b = {b1,b0}, product y = {y3,y2,y1,y0}). It drives stimulus vectors into the candidate, samples the candidate's response, and compares it against a built-in golden product. It then reports the count of correct output bits as the individual's fitness score. It sits at the opposite end of the candidate's port list: it drives the a/b inputs and reads the y outputs.

---
 rtl/mul4_eval_pkg.sv | 30 +++
 rtl/mul4_golden.sv | 18 +
 rtl/mul4_fitness_scorer.sv | 175 +++++++++++++++++
 tb/tb_mul4_fitness_scorer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul4_eval_pkg.sv
// Shared constants for the 2x2-bit multiplier fitness scorer: FSM encoding,
// exhaustive round-0 stimulus/golden vectors and the LFSR feedback mask.
package mul4_eval_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StLoad   = 3'd1;
  localparam state_t StWait   = 3'd2;
  localparam state_t StSample = 3'd3;
  localparam state_t StFinish = 3'd4;

  // Lane i carries operands a = i[3:2], b = i[1:0].
  localparam logic [15:0] Round0A1 = 16'hFF00;
  localparam logic [15:0] Round0A0 = 16'hF0F0;
  localparam logic [15:0] Round0B1 = 16'hCCCC;
  localparam logic [15:0] Round0B0 = 16'hAAAA;

  localparam logic [15:0] Round0G3 = 16'h8000;
  localparam logic [15:0] Round0G2 = 16'h4C00;
  localparam logic [15:0] Round0G1 = 16'h6AC0;
  localparam logic [15:0] Round0G0 = 16'hA0A0;

  localparam logic [15:0] LfsrMask = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LfsrMask : 16'h0000);
  endfunction

endpackage

// File: rtl/mul4_golden.sv
// Bit-sliced reference 2x2-bit multiplier: 16 independent lanes, one bit per lane.
module mul4_golden (
  input  logic [15:0] a1_i,
  input  logic [15:0] a0_i,
  input  logic [15:0] b1_i,
  input  logic [15:0] b0_i,
  output logic [15:0] g3_o,
  output logic [15:0] g2_o,
  output logic [15:0] g1_o,
  output logic [15:0] g0_o
);

  assign g0_o = a0_i & b0_i;
  assign g1_o = (a1_i & b0_i) ^ (a0_i & b1_i);
  assign g2_o = (a1_i & b1_i) & ~(a0_i & b0_i);
  assign g3_o = a1_i & a0_i & b1_i & b0_i;

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Drives stimulus rounds into a candidate 2x2 multiplier, counts correct output
// bits against the built-in golden product and reports the total as a score.
module mul4_fitness_scorer
  import mul4_eval_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS  = 4,
  parameter int unsigned DUT_LATENCY = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned SCORE_W     = $clog2(64 * NUM_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  input  logic [15:0]        y3,
  input  logic [15:0]        y2,
  input  logic [15:0]        y1,
  input  logic [15:0]        y0,
  output logic [SCORE_W-1:0] score,
  output logic               perfect
);

  localparam int unsigned RndW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam int unsigned CntW = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY + 1) : 1;
  localparam logic [RndW-1:0]    LastRound = RndW'(NUM_ROUNDS - 1);
  localparam logic [SCORE_W-1:0] FullScore = SCORE_W'(64 * NUM_ROUNDS);

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [RndW-1:0]    round_q, round_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [SCORE_W-1:0] acc_q, acc_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [15:0]        a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;

  logic [15:0] g3, g2, g1, g0;
  logic [15:0] s1, s2, s3, s4;
  logic [63:0] mismatch;
  logic [6:0]  match_cnt;

  mul4_golden u_golden (
    .a1_i (a1_q),
    .a0_i (a0_q),
    .b1_i (b1_q),
    .b0_i (b0_q),
    .g3_o (g3),
    .g2_o (g2),
    .g1_o (g1),
    .g0_o (g0)
  );

  // Four unrolled LFSR steps supply one pseudo-random round.
  assign s1 = lfsr_step(lfsr_q);
  assign s2 = lfsr_step(s1);
  assign s3 = lfsr_step(s2);
  assign s4 = lfsr_step(s3);

  assign mismatch  = {g3 ^ y3, g2 ^ y2, g1 ^ y1, g0 ^ y0};
  assign match_cnt = 7'd64 - popcount64(mismatch);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    acc_d   = acc_q;
    score_d = score_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    b1_d    = b1_q;
    b0_d    = b0_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          round_d = '0;
          lfsr_d  = LFSR_SEED;
          score_d = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (round_q == '0) begin
          a1_d = Round0A1;
          a0_d = Round0A0;
          b1_d = Round0B1;
          b0_d = Round0B0;
        end else begin
          a1_d   = s1;
          a0_d   = s2;
          b1_d   = s3;
          b0_d   = s4;
          lfsr_d = s4;
        end
        if (DUT_LATENCY == 0) begin
          state_d = StSample;
        end else begin
          cnt_d   = CntW'(DUT_LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSample: begin
        acc_d = acc_q + SCORE_W'(match_cnt);
        if (round_q == LastRound) begin
          // Publish on entry to FINISH so score is already valid alongside done.
          score_d = acc_d;
          state_d = StFinish;
        end else begin
          round_d = round_q + RndW'(1);
          state_d = StLoad;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      acc_q   <= '0;
      score_q <= '0;
      a1_q    <= '0;
      a0_q    <= '0;
      b1_q    <= '0;
      b0_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      b1_q    <= b1_d;
      b0_q    <= b0_d;
    end
  end

  assign busy    = (state_q == StLoad) || (state_q == StWait) || (state_q == StSample);
  assign done    = (state_q == StFinish);
  assign score   = score_q;
  assign perfect = (score_q == FullScore);
  assign a1      = a1_q;
  assign a0      = a0_q;
  assign b1      = b1_q;
  assign b0      = b0_q;

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Directed bench: five scorer instances, each paired with a different candidate.
module tb_mul4_fitness_scorer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start_a, start_b, start_c, start_d, start_e;
  logic busy_a, busy_b, busy_c, busy_d, busy_e;
  logic done_a, done_b, done_c, done_d, done_e;
  logic perf_a, perf_b, perf_c, perf_d, perf_e;
  logic [8:0] score_a;
  logic [6:0] score_b, score_d;
  logic [7:0] score_c, score_e;
  logic [15:0] a1_a, a0_a, b1_a, b0_a, y3_a, y2_a, y1_a, y0_a;
  logic [15:0] a1_b, a0_b, b1_b, b0_b;
  logic [15:0] a1_c, a0_c, b1_c, b0_c, y3_c, y2_c, y1_c, y0_c;
  logic [15:0] a1_d, a0_d, b1_d, b0_d, y3_d, y2_d, y1_d, g0_d;
  logic [15:0] a1_e, a0_e, b1_e, b0_e;
  logic [63:0] gc, p1, p2, p3;
  logic [4:0]  done_v;

  assign done_v = {done_e, done_d, done_c, done_b, done_a};

  // A: correct combinational candidate, 4 rounds.
  mul4_golden u_cand_a (.a1_i(a1_a), .a0_i(a0_a), .b1_i(b1_a), .b0_i(b0_a),
                        .g3_o(y3_a), .g2_o(y2_a), .g1_o(y1_a), .g0_o(y0_a));
  mul4_fitness_scorer #(.NUM_ROUNDS(4), .DUT_LATENCY(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .a1(a1_a), .a0(a0_a), .b1(b1_a), .b0(b0_a),
    .y3(y3_a), .y2(y2_a), .y1(y1_a), .y0(y0_a), .score(score_a), .perfect(perf_a));

  // B: all outputs tied low, 1 round.
  mul4_fitness_scorer #(.NUM_ROUNDS(1), .DUT_LATENCY(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .a1(a1_b), .a0(a0_b), .b1(b1_b), .b0(b0_b),
    .y3(16'h0), .y2(16'h0), .y1(16'h0), .y0(16'h0), .score(score_b), .perfect(perf_b));

  // C: correct candidate behind a 3-deep register pipe.
  mul4_golden u_cand_c (.a1_i(a1_c), .a0_i(a0_c), .b1_i(b1_c), .b0_i(b0_c),
                        .g3_o(gc[63:48]), .g2_o(gc[47:32]), .g1_o(gc[31:16]), .g0_o(gc[15:0]));
  always_ff @(posedge clk) begin
    p1 <= gc;
    p2 <= p1;
    p3 <= p2;
  end
  assign {y3_c, y2_c, y1_c, y0_c} = p3;
  mul4_fitness_scorer #(.NUM_ROUNDS(2), .DUT_LATENCY(3)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .a1(a1_c), .a0(a0_c), .b1(b1_c), .b0(b0_c),
    .y3(y3_c), .y2(y2_c), .y1(y1_c), .y0(y0_c), .score(score_c), .perfect(perf_c));

  // D: correct candidate with y0 inverted, 1 round.
  mul4_golden u_cand_d (.a1_i(a1_d), .a0_i(a0_d), .b1_i(b1_d), .b0_i(b0_d),
                        .g3_o(y3_d), .g2_o(y2_d), .g1_o(y1_d), .g0_o(g0_d));
  mul4_fitness_scorer #(.NUM_ROUNDS(1), .DUT_LATENCY(0)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .busy(busy_d), .done(done_d),
    .a1(a1_d), .a0(a0_d), .b1(b1_d), .b0(b0_d),
    .y3(y3_d), .y2(y2_d), .y1(y1_d), .y0(~g0_d), .score(score_d), .perfect(perf_d));

  // E: outputs tied low, 3 rounds, latency 2: score depends on the LFSR sequence.
  mul4_fitness_scorer #(.NUM_ROUNDS(3), .DUT_LATENCY(2)) u_e (
    .clk(clk), .rst(rst), .start(start_e), .busy(busy_e), .done(done_e),
    .a1(a1_e), .a0(a0_e), .b1(b1_e), .b0(b0_e),
    .y3(16'h0), .y2(16'h0), .y1(16'h0), .y0(16'h0), .score(score_e), .perfect(perf_e));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the accepting edge (cycle 1).
  task automatic wait_done(input int idx, output int cyc);
    cyc = 1;
    while (!done_v[idx] && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Ones in the arithmetic lane products {a1,a0} * {b1,b0}.
  function automatic int product_ones(input logic [15:0] a1, input logic [15:0] a0,
                                      input logic [15:0] b1, input logic [15:0] b0);
    int n;
    logic [3:0] p;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      p = {2'b00, a1[i], a0[i]} * {2'b00, b1[i], b0[i]};
      n += $countones(p);
    end
    return n;
  endfunction

  function automatic logic [63:0] stim_round(input int r);
    logic [15:0] s, s1, s2, s3, s4;
    logic [63:0] v;
    s = 16'hACE1;
    v = {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};
    for (int k = 1; k <= r; k++) begin
      s1 = lfsr_next(s);
      s2 = lfsr_next(s1);
      s3 = lfsr_next(s2);
      s4 = lfsr_next(s3);
      v  = {s1, s2, s3, s4};
      s  = s4;
    end
    return v;
  endfunction

  function automatic int zero_score(input int rounds);
    int tot;
    logic [63:0] v;
    tot = 0;
    for (int r = 0; r < rounds; r++) begin
      v = stim_round(r);
      tot += 64 - product_ones(v[63:48], v[47:32], v[31:16], v[15:0]);
    end
    return tot;
  endfunction

  initial begin
    int cyc, ndone, done_at, exp_e;
    exp_e = zero_score(3);
    rst = 1'b1;
    {start_a, start_b, start_c, start_d, start_e} = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_score", score_a, 0);
    check("rst_perfect", perf_a, 0);
    check("rst_stim", {a1_a, a0_a, b1_a, b0_a}, 0);

    // A: correct candidate, done at cycle 9, then start held high for a relaunch.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, cyc);
    check("a_latency", cyc, 9);
    check("a_score", score_a, 256);
    check("a_perfect", perf_a, 1);
    tick();
    check("a_done_pulse", done_a, 0);
    check("a_score_held", score_a, 256);
    start_a = 1'b1;
    tick();
    wait_done(0, cyc);
    check("a2_latency", cyc, 9);
    tick();
    check("a2_idle_busy", busy_a, 0);
    check("a2_idle_score", score_a, 256);
    tick();
    start_a = 1'b0;
    check("a2_relaunch_busy", busy_a, 1);
    check("a2_clear_score", score_a, 0);
    check("a2_clear_perfect", perf_a, 0);
    wait_done(0, cyc);
    check("a3_latency", cyc, 9);
    check("a3_score", score_a, 256);

    // B: zero candidate; round-0 golden has 14 ones.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1, cyc);
    check("b_latency", cyc, 3);
    check("b_stim", {a1_b, a0_b, b1_b, b0_b}, {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA});
    check("b_score", score_b, 50);
    check("b_perfect", perf_b, 0);

    // C: latency 3, two 5-cycle rounds, stimulus stable across each round.
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c >= 2 && c <= 5) check("c_stim_r0", {a1_c, a0_c, b1_c, b0_c}, stim_round(0));
      if (c >= 7 && c <= 10) check("c_stim_r1", {a1_c, a0_c, b1_c, b0_c}, stim_round(1));
      check("c_busy", busy_c, (c <= 10) ? 1 : 0);
      check("c_done", done_c, (c == 11) ? 1 : 0);
      if (c < 11) tick();
    end
    check("c_score", score_c, 128);
    check("c_perfect", perf_c, 1);

    // D: y0 inverted loses all 16 y0 bits.
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    tick();
    check("d_stim_sample", {a1_d, a0_d, b1_d, b0_d},
          {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA});
    wait_done(3, cyc);
    check("d_latency", cyc + 1, 3);
    check("d_score", score_d, 48);
    check("d_perfect", perf_d, 0);

    // E: uninterrupted reference run.
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    wait_done(4, cyc);
    check("e_latency", cyc, 13);
    check("e_score", score_e, exp_e);
    tick();

    // E: reset during WAIT of round 1 aborts everything.
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    repeat (5) tick();
    check("e_wait_busy", busy_e, 1);
    check("e_stim_r1", {a1_e, a0_e, b1_e, b0_e}, stim_round(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("e_rst_busy", busy_e, 0);
    check("e_rst_done", done_e, 0);
    check("e_rst_score", score_e, 0);
    check("e_rst_stim", {a1_e, a0_e, b1_e, b0_e}, 0);
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    wait_done(4, cyc);
    check("e_fresh_latency", cyc, 13);
    check("e_fresh_score", score_e, exp_e);
    tick();

    // E: start pulses while busy are ignored.
    start_e = 1'b1;
    tick();
    ndone = 0;
    done_at = 0;
    for (int c = 1; c <= 24; c++) begin
      start_e = (c == 3 || c == 8) ? 1'b1 : 1'b0;
      if (done_e) begin
        ndone++;
        done_at = c;
      end
      tick();
    end
    start_e = 1'b0;
    check("f_done_count", ndone, 1);
    check("f_done_cycle", done_at, 13);
    check("f_score", score_e, exp_e);
    check("f_idle", busy_e, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
